// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: shifts/rotates by up to STEP bits per cycle
// under a three-state IDLE/SHIFT/DONE controller.
module seq_shifter #(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err
);

    localparam logic [2:0] M_SLL = 3'b000;
    localparam logic [2:0] M_SRL = 3'b001;
    localparam logic [2:0] M_SRA = 3'b010;
    localparam logic [2:0] M_ROL = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;

    localparam logic [SHW-1:0] WIDTH_W = SHW'(WIDTH);
    localparam logic [SHW-1:0] STEP_W  = SHW'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nx;
    logic [2:0]     mode_r;
    logic           err_r;
    logic [SHW-1:0] rem, n_eff, k, k_m1;
    logic           accept, illegal;
    logic [WIDTH-1:0] shifted, lsh, rsh;
    logic           cout;

    assign accept  = (state == IDLE) && start;
    assign illegal = (mode > M_ROR);

    always_comb begin
        n_eff = '0;
        case (mode)
            M_SLL, M_SRL, M_SRA: n_eff = (shamt > WIDTH_W) ? WIDTH_W : shamt;
            M_ROL, M_ROR:        n_eff = {1'b0, shamt[SHW-2:0]};
            default:             n_eff = '0;
        endcase
    end

    // k is the chunk for this cycle; the last bit out sits one position
    // short of a full k-bit shift, so pre-shift by k-1 to reach it.
    always_comb begin
        k       = (rem < STEP_W) ? rem : STEP_W;
        k_m1    = k - SHW'(1);
        lsh     = result << k_m1;
        rsh     = result >> k_m1;
        shifted = result;
        cout    = 1'b0;
        case (mode_r)
            M_SLL: begin shifted = result << k;                 cout = lsh[WIDTH-1]; end
            M_SRL: begin shifted = result >> k;                 cout = rsh[0];       end
            M_SRA: begin shifted = $signed(result) >>> k;       cout = rsh[0];       end
            M_ROL: begin shifted = (result << k) | (result >> (WIDTH_W - k)); cout = lsh[WIDTH-1]; end
            M_ROR: begin shifted = (result >> k) | (result << (WIDTH_W - k)); cout = rsh[0];       end
            default: begin shifted = result; cout = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (n_eff != '0) ? SHIFT : DONE;
            SHIFT:   if (rem == k) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            carry  <= 1'b0;
            rem    <= '0;
            mode_r <= M_SLL;
            err_r  <= 1'b0;
        end else if (accept) begin
            result <= a;
            carry  <= 1'b0;
            rem    <= n_eff;
            mode_r <= mode;
            err_r  <= illegal;
        end else if (state == SHIFT) begin
            result <= shifted;
            carry  <= cout;
            rem    <= rem - k;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign err  = done && err_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: STEP=1 and STEP=4 instances share operand
// inputs, each with its own start; a bit-serial model supplies random expectations.
module tb_seq_shifter;

    localparam int W   = 16;
    localparam int SHW = 5;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         e;
        int           lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     start_v = '0;
    logic [2:0]     mode = '0;
    logic [W-1:0]   a = '0;
    logic [SHW-1:0] shamt = '0;
    logic [1:0]     busy_v, done_v, carry_v, err_v;
    logic [W-1:0]   res_v [2];

    seq_shifter #(.WIDTH(W), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .a(a), .shamt(shamt),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .carry(carry_v[0]), .err(err_v[0])
    );
    seq_shifter #(.WIDTH(W), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .a(a), .shamt(shamt),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .carry(carry_v[1]), .err(err_v[1])
    );

    always #5 clk = ~clk;

    int   n_cmp = 0, n_mis = 0;
    int   dn0 = 0, dn1 = 0, exp_dn0 = 0, exp_dn1 = 0;
    exp_t sb[$];

    always @(posedge clk) begin
        if (done_v[0]) dn0++;
        if (done_v[1]) dn1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference: shifting n single bits equals any chunked shift.
    task automatic model(input logic [W-1:0] ia, input logic [2:0] m, input logic [SHW-1:0] s,
                         output logic [W-1:0] r, output logic c, output logic e, output int n);
        r = ia; c = 1'b0; e = (m > 3'd4);
        if (m <= 3'd2)      n = (s > 16) ? 16 : int'(s);
        else if (m <= 3'd4) n = int'(s) % 16;
        else                n = 0;
        for (int i = 0; i < n; i++) begin
            case (m)
                3'd0: begin c = r[15]; r = {r[14:0], 1'b0};  end
                3'd1: begin c = r[0];  r = {1'b0, r[15:1]};  end
                3'd2: begin c = r[0];  r = {r[15], r[15:1]}; end
                3'd3: begin c = r[15]; r = {r[14:0], r[15]}; end
                default: begin c = r[0]; r = {r[0], r[15:1]}; end
            endcase
        end
    endtask

    // Issue one op on DUT d (called at posedge+1), wait for done, check hold.
    task automatic run_op(input int d, input logic [W-1:0] ia, input logic [2:0] im,
                          input logic [SHW-1:0] is, input logic [W-1:0] er, input logic ec,
                          input logic ee, input int lat);
        exp_t x;
        bit   got = 0;
        x.r = er; x.c = ec; x.e = ee; x.lat = lat;
        sb.push_back(x);
        a = ia; mode = im; shamt = is; start_v[d] = 1'b1;
        if (d == 0) exp_dn0++; else exp_dn1++;
        @(negedge clk);
        chk("busy_c0", busy_v[d], 0);
        tick;
        start_v[d] = 1'b0;
        a = W'($urandom); mode = 3'($urandom); shamt = SHW'($urandom);
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            chk("busy", busy_v[d], 1);
            if (done_v[d]) begin
                x = sb.pop_front();
                chk("result", res_v[d], x.r);
                chk("carry", carry_v[d], x.c);
                chk("err", err_v[d], x.e);
                chk("latency", i, x.lat);
                got = 1;
            end else begin
                tick;
            end
        end
        if (!got) begin
            chk("timeout", 0, 1);
            sb.delete();
        end
        tick;
        @(negedge clk);
        if (got) chk("hold", {done_v[d], busy_v[d], err_v[d], carry_v[d], res_v[d]},
                     {1'b0, 1'b0, 1'b0, x.c, x.r});
        tick;
    endtask

    initial begin
        int nd, dcyc, n, lat, d;
        logic [W-1:0] r, ra;
        logic c, e;
        logic [2:0] rm;
        logic [SHW-1:0] rs;

        repeat (3) tick;
        @(negedge clk);
        chk("rst_s1", {busy_v[0], done_v[0], err_v[0], carry_v[0], res_v[0]}, 0);
        chk("rst_s4", {busy_v[1], done_v[1], err_v[1], carry_v[1], res_v[1]}, 0);
        tick;
        rst_n = 1'b1;  // start accepted in the very first cycle out of reset

        run_op(0, 16'h0001, 3'b000, 5'd4,  16'h0010, 1'b0, 1'b0, 5);
        run_op(0, 16'h8000, 3'b010, 5'd3,  16'hF000, 1'b0, 1'b0, 4);
        run_op(0, 16'h0001, 3'b100, 5'd17, 16'h8000, 1'b1, 1'b0, 2);
        run_op(0, 16'hFFFF, 3'b000, 5'd20, 16'h0000, 1'b1, 1'b0, 17);
        run_op(0, 16'hFFFF, 3'b000, 5'd0,  16'hFFFF, 1'b0, 1'b0, 1);
        run_op(1, 16'h1234, 3'b000, 5'd6,  16'h8D00, 1'b0, 1'b0, 3);
        run_op(1, 16'h1234, 3'b110, 5'd6,  16'h1234, 1'b0, 1'b1, 1);
        run_op(1, 16'h8001, 3'b011, 5'd5,  16'h0030, 1'b0, 1'b0, 3);
        run_op(1, 16'h8421, 3'b001, 5'd16, 16'h0000, 1'b1, 1'b0, 5);

        for (int j = 0; j < 24; j++) begin
            d  = j % 2;
            ra = W'($urandom);
            rm = 3'($urandom_range(0, 7));
            rs = SHW'($urandom_range(0, 31));
            model(ra, rm, rs, r, c, e, n);
            lat = (n == 0) ? 1 : (n + (d ? 4 : 1) - 1) / (d ? 4 : 1) + 1;
            run_op(d, ra, rm, rs, r, c, e, lat);
        end

        // Starts in SHIFT (cycle 3) and DONE (cycle 9) must be ignored.
        nd = 0; dcyc = -1;
        a = 16'h00F0; mode = 3'b000; shamt = 5'd8; start_v[0] = 1'b1;
        exp_dn0++;
        tick;
        for (int i = 1; i <= 14; i++) begin
            start_v[0] = (i == 3 || i == 9);
            if (start_v[0]) begin a = 16'hFFFF; mode = 3'b100; shamt = 5'd1; end
            @(negedge clk);
            if (done_v[0]) begin
                nd++; dcyc = i;
                chk("ign_result", res_v[0], 16'hF000);
                chk("ign_carry", carry_v[0], 0);
            end
            tick;
        end
        start_v[0] = 1'b0;
        chk("ign_ndone", nd, 1);
        chk("ign_cycle", dcyc, 9);

        // Reset in cycle 4 aborts the op: no done, outputs cleared from cycle 5.
        nd = 0;
        a = 16'h0001; mode = 3'b000; shamt = 5'd8; start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            rst_n = (i != 4);
            @(negedge clk);
            if (done_v[0]) nd++;
            if (i >= 5) chk("abort_out", {busy_v[0], done_v[0], err_v[0], carry_v[0], res_v[0]}, 0);
            tick;
        end
        rst_n = 1'b1;
        chk("abort_ndone", nd, 0);

        chk("dones_s1", dn0, exp_dn0);
        chk("dones_s4", dn1, exp_dn1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
